// File: rtl/nmcu_scheduler.sv
// Tile scheduler: walks one convolution layer's output plane in raster order and
// hands each output pixel to the lowest-index free NMCU, retiring units on done.
module nmcu_scheduler #(
  parameter int unsigned NUM_NMCUS     = 9,
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned MAX_INPUT_DIM = 15,
  localparam int unsigned DW           = $clog2(MAX_INPUT_DIM) + 1,
  localparam int unsigned PW           = 2 * DW
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            go,
  input  logic [ADDR_WIDTH-1:0]           input_base,
  input  logic [ADDR_WIDTH-1:0]           output_base,
  input  logic [ADDR_WIDTH-1:0]           desc_addr,
  input  logic [DW-1:0]                   in_width,
  input  logic [DW-1:0]                   in_height,
  input  logic [DW-1:0]                   kernel_dim,
  output logic [NUM_NMCUS-1:0]            start,
  output logic [ADDR_WIDTH-1:0]           nmcu_desc,
  output logic [NUM_NMCUS*ADDR_WIDTH-1:0] input_addr,
  output logic [NUM_NMCUS*ADDR_WIDTH-1:0] output_addr,
  input  logic [NUM_NMCUS-1:0]            done,
  output logic                            busy,
  output logic                            finished,
  output logic                            cfg_err,
  output logic [PW-1:0]                   pixels_done
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DISPATCH = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_FINISH   = 2'd3;

  logic [1:0]                      state_q, state_d;
  logic [NUM_NMCUS-1:0]            start_q, start_d;
  logic [NUM_NMCUS-1:0]            unit_busy_q, unit_busy_d;
  logic [NUM_NMCUS*ADDR_WIDTH-1:0] in_addr_q, in_addr_d;
  logic [NUM_NMCUS*ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [ADDR_WIDTH-1:0]           desc_q, desc_d;
  logic [ADDR_WIDTH-1:0]           ib_q, ib_d;
  logic [ADDR_WIDTH-1:0]           ob_q, ob_d;
  logic [DW-1:0]                   inw_q, inw_d;
  logic [DW-1:0]                   outw_q, outw_d;
  logic [DW-1:0]                   outh_q, outh_d;
  logic [DW-1:0]                   row_q, row_d;
  logic [DW-1:0]                   col_q, col_d;
  logic [PW-1:0]                   pix_q, pix_d;
  logic                            busy_q, busy_d;
  logic                            fin_q, fin_d;
  logic                            err_q, err_d;

  logic [NUM_NMCUS-1:0]            retire;
  logic [NUM_NMCUS-1:0]            free;
  logic [NUM_NMCUS-1:0]            grant;
  logic [PW-1:0]                   retire_cnt;
  logic [ADDR_WIDTH-1:0]           pix_in_addr;
  logic [ADDR_WIDTH-1:0]           pix_out_addr;

  // Next-state, dispatch and retire logic
  always_comb begin
    state_d     = state_q;
    start_d     = start_q;
    unit_busy_d = unit_busy_q;
    in_addr_d   = in_addr_q;
    out_addr_d  = out_addr_q;
    desc_d      = desc_q;
    ib_d        = ib_q;
    ob_d        = ob_q;
    inw_d       = inw_q;
    outw_d      = outw_q;
    outh_d      = outh_q;
    row_d       = row_q;
    col_d       = col_q;
    pix_d       = pix_q;
    err_d       = 1'b0;

    retire     = unit_busy_q & done;
    // A unit still showing a stale done is not offered new work.
    free       = ~unit_busy_q & ~done;
    grant      = free & (~free + NUM_NMCUS'(1));
    retire_cnt = '0;
    for (int k = 0; k < int'(NUM_NMCUS); k++) begin
      retire_cnt = retire_cnt + PW'(retire[k]);
    end
    pix_in_addr  = ib_q + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(inw_q) + ADDR_WIDTH'(col_q);
    pix_out_addr = ob_q + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(outw_q) + ADDR_WIDTH'(col_q);

    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (kernel_dim == '0 || kernel_dim > in_width || kernel_dim > in_height) begin
            err_d = 1'b1;
          end else begin
            desc_d  = desc_addr;
            ib_d    = input_base;
            ob_d    = output_base;
            inw_d   = in_width;
            outw_d  = in_width - kernel_dim + DW'(1);
            outh_d  = in_height - kernel_dim + DW'(1);
            row_d   = '0;
            col_d   = '0;
            pix_d   = '0;
            state_d = S_DISPATCH;
          end
        end
      end
      S_DISPATCH: begin
        if (|grant) begin
          for (int k = 0; k < int'(NUM_NMCUS); k++) begin
            if (grant[k]) begin
              start_d[k]     = 1'b1;
              unit_busy_d[k] = 1'b1;
              in_addr_d[k*ADDR_WIDTH +: ADDR_WIDTH]  = pix_in_addr;
              out_addr_d[k*ADDR_WIDTH +: ADDR_WIDTH] = pix_out_addr;
            end
          end
          if (col_q == outw_q - DW'(1)) begin
            col_d = '0;
            row_d = row_q + DW'(1);
            if (row_q == outh_q - DW'(1)) begin
              state_d = S_DRAIN;
            end
          end else begin
            col_d = col_q + DW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (unit_busy_q == '0) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE) begin
      start_d     = start_d & ~retire;
      unit_busy_d = unit_busy_d & ~retire;
      pix_d       = pix_q + retire_cnt;
    end

    fin_d  = (state_d == S_FINISH);
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_q     <= '0;
      unit_busy_q <= '0;
      in_addr_q   <= '0;
      out_addr_q  <= '0;
      desc_q      <= '0;
      ib_q        <= '0;
      ob_q        <= '0;
      inw_q       <= '0;
      outw_q      <= '0;
      outh_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      pix_q       <= '0;
      busy_q      <= 1'b0;
      fin_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start_d;
      unit_busy_q <= unit_busy_d;
      in_addr_q   <= in_addr_d;
      out_addr_q  <= out_addr_d;
      desc_q      <= desc_d;
      ib_q        <= ib_d;
      ob_q        <= ob_d;
      inw_q       <= inw_d;
      outw_q      <= outw_d;
      outh_q      <= outh_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pix_q       <= pix_d;
      busy_q      <= busy_d;
      fin_q       <= fin_d;
      err_q       <= err_d;
    end
  end

  assign start       = start_q;
  assign nmcu_desc   = desc_q;
  assign input_addr  = in_addr_q;
  assign output_addr = out_addr_q;
  assign busy        = busy_q;
  assign finished    = fin_q;
  assign cfg_err     = err_q;
  assign pixels_done = pix_q;

endmodule

// File: doc/nmcu_scheduler.md
# nmcu_scheduler

Tile scheduler that sequences a pool of NMCUs over one convolution layer. Given an input feature map base/size, output base and kernel size, it walks the output plane in raster order and hands each output pixel to a free NMCU by driving that unit's `start`, `input_addr` and `output_addr`. It retires units on `done` and raises `finished` once every pixel is complete. It sits between the host/config side and the NMCU array; the NMCUs still reach memory through `mem_interface`.

## Interface
- `NUM_NMCUS`, 9: number of NMCU ports driven.
- `ADDR_WIDTH`, 16: address width.
- `MAX_INPUT_DIM`, 15: largest input width/height; dimension fields are `DW = $clog2(MAX_INPUT_DIM)+1` bits.

Ports:
- `clk`  in  1  clock. One clock domain; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `go`  in  1  start a layer; sampled only in IDLE.
- `input_base`  in  ADDR_WIDTH  address of input pixel (0,0).
- `output_base`  in  ADDR_WIDTH  address of output pixel (0,0).
- `desc_addr`  in  ADDR_WIDTH  descriptor address for the whole layer.
- `in_width`, `in_height`  in  DW  input dimensions.
- `kernel_dim`  in  DW  square kernel size.
- `start`  out  NUM_NMCUS  per-unit start level.
- `nmcu_desc`  out  ADDR_WIDTH  latched `desc_addr`, shared by all units.
- `input_addr`  out  NUM_NMCUS*ADDR_WIDTH  per-unit input address; unit k uses slice [k*ADDR_WIDTH +: ADDR_WIDTH].
- `output_addr`  out  NUM_NMCUS*ADDR_WIDTH  per-unit output address; same slicing.
- `done`  in  NUM_NMCUS  per-unit completion.
- `busy`  out  1  high outside IDLE.
- `finished`  out  1  one-cycle pulse when the layer is complete.
- `cfg_err`  out  1  one-cycle pulse when a `go` is rejected.
- `pixels_done`  out  2*DW  count of retired pixels in the current layer.

## Operation
- States: IDLE, DISPATCH, DRAIN, FINISH.
- **IDLE**
  - On `go`, latch all config fields.
  - Compute `out_w = in_width - kernel_dim + 1` and `out_h = in_height - kernel_dim + 1`.
  - Clear `row`, `col`, `pixels_done`, then go to DISPATCH.
  - If `kernel_dim == 0`, `kernel_dim > in_width` or `kernel_dim > in_height`: pulse `cfg_err`, stay in IDLE, drive no `start`.
- **Per-unit state**
  - `unit_busy[k]`.
  - Unit k is free when `unit_busy[k]==0 && done[k]==0`. A stale high `done` blocks re-dispatch until it drops.
- **DISPATCH**
  - Each cycle, pick the lowest-index free unit, if any.
  - Set its `start`=1 and `unit_busy`=1.
  - `input_addr[k] = input_base + row*in_width + col`.
  - `output_addr[k] = output_base + row*out_w + col`.
  - Advance `col`; on `col == out_w-1` wrap to 0 and increment `row`.
  - At most one dispatch per cycle.
  - After the pixel (`out_h-1`, `out_w-1`) is dispatched, go to DRAIN.
- **Retire, any state except IDLE**
  - For every k with `unit_busy[k] && done[k]`, clear `start[k]` and `unit_busy[k]` and increment `pixels_done`.
  - Multiple units may retire on the same edge; `pixels_done` adds the popcount.
  - A unit retiring on an edge is not free on that edge. It is re-dispatchable only once `done[k]` is low.
- **DRAIN:** when `unit_busy == 0`, go to FINISH.
- **FINISH:** `finished`=1 for one cycle, then IDLE. `pixels_done` holds its value until the next accepted `go`.
- `input_addr`/`output_addr` for a unit hold stable from dispatch until the unit's next dispatch.
- Address arithmetic is unsigned, truncated to ADDR_WIDTH; wrap past 0xFFFF is not flagged.
- `done` from a unit with `unit_busy==0` is ignored.
- `go` outside IDLE is ignored.

## Timing
- **Reset:** `rst` high at an edge forces:
  - state IDLE;
  - `start`=0, `unit_busy`=0, `input_addr`=0, `output_addr`=0, `nmcu_desc`=0;
  - `busy`=0, `finished`=0, `cfg_err`=0, `pixels_done`=0.
  - This applies mid-layer too; in-flight NMCUs are abandoned.
- **Dispatch latency:** with `go` sampled at edge N, `start[0]` and its addresses are valid after edge N+1. With all units free, unit k dispatches at edge N+1+k.
- **Retire latency:** `done[k]` sampled high at edge M → `start[k]` low after edge M.
- **Completion:** last retire at edge M → FINISH after M+1 → `finished` high for one cycle in the M+1..M+2 window; `busy` falls after M+2.
- `cfg_err` is high for the single cycle after the rejected `go` edge.
- All outputs are registered.

## Test plan
- **6x6 input, kernel 4, 9 units.** `input_base`=0x0100, `output_base`=0x0200, each unit's `done` 5 cycles after its `start`.
  - Starts rise on 9 consecutive cycles.
  - Input addrs 0x0100, 0x0101, 0x0102, 0x0106, 0x0107, 0x0108, 0x010C, 0x010D, 0x010E.
  - Output addrs 0x0200–0x0208.
  - `pixels_done`=9; `finished` pulses once.
- **Same layer, `NUM_NMCUS`=2, `done` held high 2 cycles.**
  - 9 dispatches alternate between units 0/1 in raster order.
  - No unit is re-dispatched while its `done` is high.
  - `finished` follows the ninth retire.
- **Simultaneous retire.** Units 0, 3 and 5 assert `done` on the same edge → `pixels_done` +3 and all three `start` drop on that edge.
- **Invalid config:** `kernel_dim`=7 with a 6x6 input → `cfg_err` pulse; `start`=0 and `busy`=0 throughout.
- **Reset mid-layer.** Assert `rst` after 4 dispatches → next cycle all outputs are at reset values. A subsequent `go` replays from pixel (0,0).
- **Extra `go` while busy.** Pulse `go` during DISPATCH → ignored; config and the address sequence are unchanged.
